// File: rtl/k2_mem_pkg.sv
// k2_mem_pkg: shared definitions for the K2 data-memory controller.
//   state_t   - controller FSM states (IDLE, WAIT, DONE)
//   MAX_WAIT  - largest supported wait-state count
//   CNT_W     - width of the wait-state down-counter
package k2_mem_pkg;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/k2_mem_array.sv
// k2_mem_array: 2**ADDR_W x WIDTH register array.
// Ports:
//   clk, rst       - clock; synchronous active-high clear of every word
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - combinational read port
module k2_mem_array #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/k2_data_mem_ctrl.sv
// k2_data_mem_ctrl: data-memory controller for the K2 core with a
// request/busy handshake, WAIT_STATES extra cycles per access and one
// memory-mapped output register at IO_ADDR (shadows that array word).
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   req/we/addr/wdata- access request, captured together when the FSM is IDLE
//   rdata, rvalid    - registered read data; rvalid pulses the cycle it is valid
//   busy             - stall request to the core (PC_en = ~busy)
//   io_out, io_strobe- output register; io_strobe pulses the cycle after update
//
// Handshake: an access is accepted in any cycle where the FSM is IDLE and
// req=1. With N=WAIT_STATES, the access executes at the edge ending cycle
// t+N, and rvalid/io_strobe are high in cycle t+N+1 only. busy is high in
// cycles t..t+N (combinationally in t) and never asserted when N=0. req is
// ignored outside IDLE, so a new request may be issued in the rvalid cycle.
module k2_data_mem_ctrl
    import k2_mem_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int WAIT_STATES = 1,
    parameter int IO_ADDR     = 2 ** ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              busy,
    output logic [WIDTH-1:0]  io_out,
    output logic              io_strobe
);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
            $error("k2_data_mem_ctrl: WAIT_STATES must be within 0..15");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_ADDR);

    // DONE is the execute cycle, so WAIT covers N-1 cycles: the counter
    // starts at N-2 and WAIT exits when it reaches zero. N=1 skips WAIT and
    // N=0 executes straight out of IDLE.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES >= 2) ? CNT_W'(WAIT_STATES - 2) : '0;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_wdata;

    logic              accept;
    logic              exec;
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [WIDTH-1:0]  op_wdata;
    logic              op_io;
    logic [WIDTH-1:0]  arr_rdata;

    // In IDLE the operands come straight from the port (only used when N=0);
    // in DONE they come from the values latched at accept.
    assign op_we    = (state == IDLE) ? we    : lat_we;
    assign op_addr  = (state == IDLE) ? addr  : lat_addr;
    assign op_wdata = (state == IDLE) ? wdata : lat_wdata;
    assign op_io    = (op_addr == IO_A);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        exec     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        exec = 1'b1;
                    end else if (WAIT_STATES == 1) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DONE: begin
                exec     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = ~rst & (((state == IDLE) & req & (WAIT_STATES != 0)) |
                          (state != IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            io_out    <= '0;
            io_strobe <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            if (accept) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
            end
            rvalid    <= exec & ~op_we;
            io_strobe <= exec & op_we & op_io;
            if (exec & op_we & op_io) begin
                io_out <= op_wdata;
            end
            if (exec & ~op_we) begin
                rdata <= op_io ? io_out : arr_rdata;
            end
        end
    end

    // Writes to IO_ADDR land in io_out only; the shadowed array word is left alone.
    k2_mem_array #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (exec & op_we & ~op_io & ~rst),
        .waddr (op_addr),
        .wdata (op_wdata),
        .raddr (op_addr),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_k2_data_mem_ctrl.sv
// Directed bench for k2_data_mem_ctrl. Four instances with WAIT_STATES
// 0, 1, 3 and 4 share one clock; each scenario task drives one instance.
// Inputs change 1 time unit after the rising edge, outputs are sampled
// 1 unit later.
module tb_k2_data_mem_ctrl;

    localparam int NS [4] = '{0, 1, 3, 4};

    logic       clk;
    logic       rst       [4];
    logic       req       [4];
    logic       we        [4];
    logic [2:0] addr      [4];
    logic [7:0] wdata     [4];
    logic [7:0] rdata     [4];
    logic       rvalid    [4];
    logic       busy      [4];
    logic [7:0] io_out    [4];
    logic       io_strobe [4];

    int total = 0;
    int bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        k2_data_mem_ctrl #(
            .WIDTH       (8),
            .ADDR_W      (3),
            .WAIT_STATES (NS[g]),
            .IO_ADDR     (7)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req       (req[g]),
            .we        (we[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .rdata     (rdata[g]),
            .rvalid    (rvalid[g]),
            .busy      (busy[g]),
            .io_out    (io_out[g]),
            .io_strobe (io_strobe[g])
        );
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int g, input logic [2:0] a, input logic [7:0] d);
        cyc();
        req[g] = 1'b1; we[g] = 1'b1; addr[g] = a; wdata[g] = d;
        repeat (NS[g] + 1) begin
            cyc();
            req[g] = 1'b0; we[g] = 1'b0;
        end
    endtask

    // Issues one read and waits (bounded) for rvalid; ends at the sample
    // point of the rvalid cycle.
    task automatic do_read(input int g, input logic [2:0] a,
                           output logic [7:0] d, output bit ok);
        cyc();
        req[g] = 1'b1; we[g] = 1'b0; addr[g] = a;
        ok = 1'b0;
        d  = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            cyc();
            req[g] = 1'b0;
            #1;
            if (rvalid[g] === 1'b1) begin
                ok = 1'b1;
                d  = rdata[g];
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            cyc();
            rst[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd5;
            #1;
            total++;
            if (busy[1] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy[1]); end
            total++;
            if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid[1]); end
            total++;
            if (io_out[1] !== 8'h00) begin bad++; $display("FAIL reset_io_out: got %h want 00", io_out[1]); end
        end
        // first cycle out of reset: request still high, N=1 -> busy now
        cyc();
        rst[1] = 1'b0;
        #1;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL reset_accept_busy: got %b want 1", busy[1]); end
        cyc();
        req[1] = 1'b0;
        #1;
        total++;
        if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL reset_early_rvalid: got %b want 0", rvalid[1]); end
        cyc();
        #1;
        total++;
        if (rvalid[1] !== 1'b1) begin bad++; $display("FAIL reset_read_rvalid: got %b want 1", rvalid[1]); end
        total++;
        if (rdata[1] !== 8'h00) begin bad++; $display("FAIL reset_read_rdata: got %h want 00", rdata[1]); end
        do_read(1, 3'd5, d, ok);
        total++;
        if (!ok || d !== 8'h00) begin bad++; $display("FAIL reset_reread5: ok=%0d got %h want 00", ok, d); end
    endtask

    task automatic test_zero_wait();
        cyc();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 3'd2; wdata[0] = 8'hA5;
        #1;
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL zw_busy_wr: got %b want 0", busy[0]); end
        cyc();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd2;
        #1;
        total++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL zw_busy_rd: got %b want 0", busy[0]); end
        total++;
        if (io_strobe[0] !== 1'b0) begin bad++; $display("FAIL zw_strobe: got %b want 0", io_strobe[0]); end
        total++;
        if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL zw_rvalid_after_wr: got %b want 0", rvalid[0]); end
        cyc();
        req[0] = 1'b0;
        #1;
        total++;
        if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL zw_rvalid: got %b want 1", rvalid[0]); end
        total++;
        if (rdata[0] !== 8'hA5) begin bad++; $display("FAIL zw_rdata: got %h want a5", rdata[0]); end
        cyc();
        #1;
        total++;
        if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL zw_rvalid_pulse: got %b want 0", rvalid[0]); end
        total++;
        if (rdata[0] !== 8'hA5) begin bad++; $display("FAIL zw_rdata_hold: got %h want a5", rdata[0]); end
    endtask

    task automatic test_wait_states();
        logic [7:0] d;
        bit ok;
        do_write(2, 3'd1, 8'h3C);
        cyc();
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 3'd1;
        #1;
        total++;
        if (busy[2] !== 1'b1) begin bad++; $display("FAIL w3_busy_t0: got %b want 1", busy[2]); end
        for (int k = 1; k <= 3; k++) begin
            // a competing write request while busy must be ignored
            cyc();
            req[2] = 1'b1; we[2] = 1'b1; addr[2] = 3'd1; wdata[2] = 8'hEE;
            #1;
            total++;
            if (busy[2] !== 1'b1) begin bad++; $display("FAIL w3_busy_t%0d: got %b want 1", k, busy[2]); end
            total++;
            if (rvalid[2] !== 1'b0) begin bad++; $display("FAIL w3_rvalid_t%0d: got %b want 0", k, rvalid[2]); end
        end
        cyc();
        req[2] = 1'b0; we[2] = 1'b0;
        #1;
        total++;
        if (rvalid[2] !== 1'b1) begin bad++; $display("FAIL w3_rvalid_t4: got %b want 1", rvalid[2]); end
        total++;
        if (rdata[2] !== 8'h3C) begin bad++; $display("FAIL w3_rdata: got %h want 3c", rdata[2]); end
        total++;
        if (busy[2] !== 1'b0) begin bad++; $display("FAIL w3_busy_t4: got %b want 0", busy[2]); end
        cyc();
        #1;
        total++;
        if (rvalid[2] !== 1'b0) begin bad++; $display("FAIL w3_rvalid_t5: got %b want 0", rvalid[2]); end
        do_read(2, 3'd1, d, ok);
        total++;
        if (!ok || d !== 8'h3C) begin bad++; $display("FAIL w3_ignored_req: ok=%0d got %h want 3c", ok, d); end
    endtask

    task automatic test_io_reg();
        logic [7:0] d;
        bit ok;
        cyc();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd7; wdata[1] = 8'h5A;
        #1;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL io_busy: got %b want 1", busy[1]); end
        cyc();
        req[1] = 1'b0; we[1] = 1'b0;
        #1;
        total++;
        if (io_strobe[1] !== 1'b0 || io_out[1] !== 8'h00) begin
            bad++; $display("FAIL io_early: strobe=%b out=%h want 0/00", io_strobe[1], io_out[1]);
        end
        cyc();
        #1;
        total++;
        if (io_strobe[1] !== 1'b1) begin bad++; $display("FAIL io_strobe: got %b want 1", io_strobe[1]); end
        total++;
        if (io_out[1] !== 8'h5A) begin bad++; $display("FAIL io_out: got %h want 5a", io_out[1]); end
        total++;
        if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL io_no_rvalid: got %b want 0", rvalid[1]); end
        cyc();
        #1;
        total++;
        if (io_strobe[1] !== 1'b0) begin bad++; $display("FAIL io_strobe_pulse: got %b want 0", io_strobe[1]); end
        do_read(1, 3'd7, d, ok);
        total++;
        if (!ok || d !== 8'h5A) begin bad++; $display("FAIL io_readback: ok=%0d got %h want 5a", ok, d); end
        total++;
        if (g_dut[1].u_dut.u_array.mem[7] !== 8'h00) begin
            bad++; $display("FAIL io_shadow_word: got %h want 00", g_dut[1].u_dut.u_array.mem[7]);
        end
    endtask

    task automatic test_back_to_back();
        cyc();
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd0; wdata[1] = 8'h11;
        cyc();
        req[1] = 1'b0; we[1] = 1'b0;
        #1;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL b2b_busy_wr: got %b want 1", busy[1]); end
        cyc();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 3'd0;
        #1;
        total++;
        if (busy[1] !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy[1]); end
        cyc();
        req[1] = 1'b0;
        #1;
        total++;
        if (rvalid[1] !== 1'b0) begin bad++; $display("FAIL b2b_rvalid_early: got %b want 0", rvalid[1]); end
        cyc();
        #1;
        total++;
        if (rvalid[1] !== 1'b1) begin bad++; $display("FAIL b2b_rvalid: got %b want 1", rvalid[1]); end
        total++;
        if (rdata[1] !== 8'h11) begin bad++; $display("FAIL b2b_rdata: got %h want 11", rdata[1]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bit ok;
        cyc();
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 3'd3; wdata[3] = 8'hFF;
        cyc();
        req[3] = 1'b0; we[3] = 1'b0;
        #1;
        total++;
        if (busy[3] !== 1'b1) begin bad++; $display("FAIL rm_busy_t1: got %b want 1", busy[3]); end
        cyc();
        rst[3] = 1'b1;
        #1;
        total++;
        if (busy[3] !== 1'b0) begin bad++; $display("FAIL rm_busy_in_rst: got %b want 0", busy[3]); end
        cyc();
        rst[3] = 1'b0;
        #1;
        total++;
        if (busy[3] !== 1'b0) begin bad++; $display("FAIL rm_busy_after: got %b want 0", busy[3]); end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (io_strobe[3] !== 1'b0 || rvalid[3] !== 1'b0) begin
                bad++; $display("FAIL rm_no_pulse_%0d: strobe=%b rvalid=%b want 0/0", k, io_strobe[3], rvalid[3]);
            end
            cyc();
            #1;
        end
        do_read(3, 3'd3, d, ok);
        total++;
        if (!ok || d !== 8'h00) begin bad++; $display("FAIL rm_readback: ok=%0d got %h want 00", ok, d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 4; g++) begin
            rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
        end
        repeat (3) cyc();
        for (int g = 0; g < 4; g++) rst[g] = 1'b0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_io_reg();
        test_back_to_back();
        test_reset_mid();
        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
